// File: rtl/instruction_cache.sv
// ---------------------------------------------------------------------------
// instruction_cache
//
// Direct-mapped, read-only instruction cache between the CPU fetch stage and
// a 16-byte-block instruction memory. A hit returns the 32-bit instruction in
// the same cycle with no stall. A miss holds the CPU on busywait while the
// whole 128-bit block is refilled from memory.
//
// Ports:
//   clock         in   1    system clock, posedge active
//   reset         in   1    asynchronous, active-low (0 = reset)
//   read          in   1    CPU fetch request
//   address       in   10   PC byte address
//   instruction   out  32   fetched instruction word (0 unless IDLE hit)
//   busywait      out  1    CPU stall
//   mem_read      out  1    block read request to instruction memory
//   mem_address   out  6    block address to instruction memory
//   mem_readdata  in   128  block from memory, byte k = bits [8k+7:8k]
//   mem_busywait  in   1    memory busy
//
// Optional feature macro: ICACHE_STATS_EN
//   When defined, adds hit_count[15:0] / miss_count[15:0] saturating counters.
// ---------------------------------------------------------------------------
module instruction_cache #(
    parameter int NUM_BLOCKS = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         read,
    input  logic [9:0]   address,
    output logic [31:0]  instruction,
    output logic         busywait,
    output logic         mem_read,
    output logic [5:0]   mem_address,
    input  logic [127:0] mem_readdata,
    input  logic         mem_busywait
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0]  hit_count,
    output logic [15:0]  miss_count
`endif
);

    localparam int INDEX_W = $clog2(NUM_BLOCKS);
    localparam int TAG_W   = 6 - INDEX_W;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   issued_q, issued_d;
    logic [5:0]             missAddr_q, missAddr_d;
    logic [127:0]           fillData_q, fillData_d;
    logic                   memRead_q, memRead_d;
    logic [5:0]             memAddress_q, memAddress_d;
    logic [NUM_BLOCKS-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]       tagArray_q  [NUM_BLOCKS];
    logic [127:0]           dataArray_q [NUM_BLOCKS];

    logic [INDEX_W-1:0]     reqIndex;
    logic [TAG_W-1:0]       reqTag;
    logic [1:0]             reqWord;
    logic [INDEX_W-1:0]     missIndex;
    logic [TAG_W-1:0]       missTag;
    logic                   hit;
    logic                   idle;
    logic                   writeLine;
    logic                   unusedAddrBits;

`ifdef ICACHE_STATS_EN
    logic [15:0]            hitCount_q, hitCount_d;
    logic [15:0]            missCount_q, missCount_d;
`endif

    // Address split: the byte offset within a word never matters for fetch.
    assign reqIndex       = address[4 +: INDEX_W];
    assign reqTag         = address[9 -: TAG_W];
    assign reqWord        = address[3:2];
    assign missIndex      = missAddr_q[INDEX_W-1:0];
    assign missTag        = missAddr_q[5 -: TAG_W];
    assign unusedAddrBits = ^address[1:0];

    assign idle = (state_q == IDLE);
    assign hit  = read & valid_q[reqIndex] & (tagArray_q[reqIndex] == reqTag);

    // Outputs are gated by reset so that asserting reset mid-miss drops the
    // stall immediately, even though the CPU may still be holding read high.
    assign instruction = (reset && idle && hit)
                         ? dataArray_q[reqIndex][{reqWord, 5'b00000} +: 32]
                         : 32'h0;
    assign busywait    = reset & (idle ? (read & ~hit) : 1'b1);
    assign mem_read    = memRead_q;
    assign mem_address = memAddress_q;

    // The line is written on the clock edge that leaves UPDATE.
    assign writeLine = reset & (state_q == UPDATE);

    // Next-state logic. The first MEM_READ cycle only marks the request as
    // issued so the memory sees a clean request before its busywait is trusted.
    always_comb begin
        state_d      = state_q;
        issued_d     = issued_q;
        missAddr_d   = missAddr_q;
        fillData_d   = fillData_q;
        memRead_d    = memRead_q;
        memAddress_d = memAddress_q;
        valid_d      = valid_q;
        case (state_q)
            IDLE: begin
                if (read && !hit) begin
                    state_d      = MEM_READ;
                    missAddr_d   = address[9:4];
                    issued_d     = 1'b0;
                    memRead_d    = 1'b1;
                    memAddress_d = address[9:4];
                end
            end
            MEM_READ: begin
                if (!issued_q) begin
                    issued_d = 1'b1;
                end else if (!mem_busywait) begin
                    state_d      = UPDATE;
                    fillData_d   = mem_readdata;
                    issued_d     = 1'b0;
                    memRead_d    = 1'b0;
                    memAddress_d = 6'h0;
                end
            end
            UPDATE: begin
                valid_d[missIndex] = 1'b1;
                state_d            = IDLE;
            end
            default: begin
                state_d      = IDLE;
                memRead_d    = 1'b0;
                memAddress_d = 6'h0;
            end
        endcase
    end

`ifdef ICACHE_STATS_EN
    // Saturating event counters.
    always_comb begin
        hitCount_d  = hitCount_q;
        missCount_d = missCount_q;
        if (idle && hit && hitCount_q != 16'hFFFF) begin
            hitCount_d = hitCount_q + 16'd1;
        end
        if (idle && read && !hit && missCount_q != 16'hFFFF) begin
            missCount_d = missCount_q + 16'd1;
        end
    end

    assign hit_count  = hitCount_q;
    assign miss_count = missCount_q;
`endif

    // Control state. Reset abandons any fill in progress and invalidates
    // every line.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            issued_q     <= 1'b0;
            missAddr_q   <= 6'h0;
            fillData_q   <= 128'h0;
            memRead_q    <= 1'b0;
            memAddress_q <= 6'h0;
            valid_q      <= '0;
`ifdef ICACHE_STATS_EN
            hitCount_q   <= 16'h0;
            missCount_q  <= 16'h0;
`endif
        end else begin
            state_q      <= state_d;
            issued_q     <= issued_d;
            missAddr_q   <= missAddr_d;
            fillData_q   <= fillData_d;
            memRead_q    <= memRead_d;
            memAddress_q <= memAddress_d;
            valid_q      <= valid_d;
`ifdef ICACHE_STATS_EN
            hitCount_q   <= hitCount_d;
            missCount_q  <= missCount_d;
`endif
        end
    end

    // Tag and data storage need no reset; the valid bits guard them.
    always_ff @(posedge clock) begin
        if (writeLine) begin
            dataArray_q[missIndex] <= fillData_q;
            tagArray_q[missIndex]  <= missTag;
        end
    end

endmodule
